// File: rtl/ascon_pack.sv
// Shared Ascon types and constants: state type, diffusion rotation pairs,
// and the FSM/iteration constants of the iterative inverse diffusion block.
package ascon_pack;

   typedef logic [4:0][63:0] type_state;

   // Right-rotation amounts for the five word functions Sigma_i.
   localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
   localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

   // Sigma_i^64 = identity over GF(2)[X]/(X^64+1), so 63 forward passes invert.
   localparam int INV_DIFF_ITER  = 63;
   localparam int INV_DIFF_CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } type_inv_diff_fsm;

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

endpackage

// File: rtl/diffusion_layer.sv
// Forward Ascon linear diffusion layer: each word x ^ rotr(x,a) ^ rotr(x,b).
// Purely combinational; all five words are processed in parallel.
module diffusion_layer
   import ascon_pack::*;
(
   input  type_state diffusion_i,
   output type_state diffusion_o
);

   for (genvar g = 0; g < 5; g++) begin : g_word
      assign diffusion_o[g] = diffusion_i[g]
                            ^ rotr(diffusion_i[g], ROT_A[g])
                            ^ rotr(diffusion_i[g], ROT_B[g]);
   end

endmodule

// File: rtl/inv_diffusion_layer_seq.sv
// Iterative inverse of the Ascon diffusion layer: the forward layer is applied
// N_ITER times to a registered state, one application per clock.
module inv_diffusion_layer_seq
   import ascon_pack::*;
#(
   parameter int N_ITER = INV_DIFF_ITER
)(
   input  logic      clock_i,
   input  logic      resetb_i,
   input  logic      start_i,
   input  type_state inv_diffusion_i,
   output logic      busy_o,
   output logic      done_o,
   output type_state inv_diffusion_o
);

   localparam logic [INV_DIFF_CNT_W-1:0] LAST_CNT = INV_DIFF_CNT_W'(N_ITER - 1);

   type_inv_diff_fsm            r_fsm,   w_fsm_nxt;
   logic [INV_DIFF_CNT_W-1:0]   r_cnt,   w_cnt_nxt;
   type_state                   r_state, w_state_nxt;
   type_state                   w_diff;

   diffusion_layer u_diffusion_layer (
      .diffusion_i (r_state),
      .diffusion_o (w_diff)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      w_fsm_nxt   = r_fsm;
      w_cnt_nxt   = r_cnt;
      w_state_nxt = r_state;
      unique case (r_fsm)
         IDLE: begin
            if (start_i) begin
               w_state_nxt = inv_diffusion_i;
               w_cnt_nxt   = '0;
               w_fsm_nxt   = RUN;
            end
         end
         RUN: begin
            // A counter outside 0..N_ITER-1 can only come from corruption; bail out.
            if (r_cnt > LAST_CNT) begin
               w_fsm_nxt = IDLE;
            end else begin
               w_state_nxt = w_diff;
               w_cnt_nxt   = r_cnt + 1'b1;
               if (r_cnt == LAST_CNT) w_fsm_nxt = DONE;
            end
         end
         DONE:    w_fsm_nxt = IDLE;
         default: w_fsm_nxt = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments only; the wide data
   // register is reset too, so no stale result survives an aborted run.
   always_ff @(posedge clock_i) begin
      if (!resetb_i) begin
         r_fsm   <= IDLE;
         r_cnt   <= '0;
         r_state <= '0;
      end else begin
         r_fsm   <= w_fsm_nxt;
         r_cnt   <= w_cnt_nxt;
         r_state <= w_state_nxt;
      end
   end

   assign busy_o          = (r_fsm == RUN);
   assign done_o          = (r_fsm == DONE);
   assign inv_diffusion_o = r_state;

endmodule

// File: tb/tb_inv_diffusion_layer_seq.sv
// Self-checking bench for inv_diffusion_layer_seq: a bit-level model of the
// forward layer plus an edge-count timeline predicts every output each cycle.
module tb_inv_diffusion_layer_seq;
   import ascon_pack::*;

   logic      clk    = 1'b0;
   logic      resetb = 1'b0;
   logic      start  = 1'b0;
   type_state din    = '0;
   logic      busy, done;
   type_state dout;

   type_state ref_in = '0;
   type_state ref_out;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;
   int n_done      = 0;

   always #5 clk = ~clk;

   inv_diffusion_layer_seq dut (
      .clock_i         (clk),
      .resetb_i        (resetb),
      .start_i         (start),
      .inv_diffusion_i (din),
      .busy_o          (busy),
      .done_o          (done),
      .inv_diffusion_o (dout)
   );

   diffusion_layer u_ref (
      .diffusion_i (ref_in),
      .diffusion_o (ref_out)
   );

   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Bit-level model: result bit i of rotr(x,a) is x[(i+a) mod 64].
   function automatic logic [63:0] m_sigma(input logic [63:0] x, input int a, input int b);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[i] = x[i] ^ x[(i + a) % 64] ^ x[(i + b) % 64];
      return y;
   endfunction

   function automatic type_state m_diff(input type_state s);
      type_state r;
      r[0] = m_sigma(s[0], 19, 28);
      r[1] = m_sigma(s[1], 61, 39);
      r[2] = m_sigma(s[2],  1,  6);
      r[3] = m_sigma(s[3], 10, 17);
      r[4] = m_sigma(s[4],  7, 41);
      return r;
   endfunction

   // Timeline model: es = edges since the accepted start (-1 when idle).
   // es 0..62 is busy with Sigma^es applied; es 63 is the single done cycle.
   int        es  = -1;
   type_state m_q = '0;

   always @(posedge clk) begin
      if (!resetb) begin
         es  = -1;
         m_q = '0;
      end else if (es < 0) begin
         if (start) begin
            m_q = din;
            es  = 0;
         end
      end else if (es < 63) begin
         m_q = m_diff(m_q);
         es++;
      end else begin
         es = -1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",  320'(busy), 320'(es >= 0 && es < 63));
         check("done",  320'(done), 320'(es == 63));
         check("state", dout, m_q);
         if (done) n_done++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Starts one inversion, waits (bounded) for done, returns the result and
   // leaves the DUT back in IDLE.
   task automatic run_op(input type_state in, output type_state res);
      int n;
      start = 1'b1;
      din   = in;
      tick();
      start = 1'b0;
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      check("done_timeout", 320'(done), 320'(1));
      check("latency", 320'(n + 1), 320'(64));
      res = dout;
      tick();
      check("done_pulse_width", 320'(done), 320'(0));
   endtask

   type_state x_vec, p_vec, y_vec, alt, zero_s, bit_s, sig_s, exp_s;
   int        d0;

   initial begin
      x_vec[0] = 64'h78e2cc41faabaa1a;
      x_vec[1] = 64'hbc7a2e775aababf7;
      x_vec[2] = 64'h4b81c0cbbdb5fc1a;
      x_vec[3] = 64'hb22e133e424f0250;
      x_vec[4] = 64'h044d33702433805d;
      zero_s   = '0;
      alt      = ~x_vec;

      // 1. Reset with start held high: nothing is taken.
      resetb = 1'b0;
      start  = 1'b1;
      din    = x_vec;
      tick();
      chk_en = 1'b1;
      tick();
      check("rst_state", dout, zero_s);
      check("rst_busy",  320'(busy), 320'(0));
      check("rst_done",  320'(done), 320'(0));
      start  = 1'b0;
      resetb = 1'b1;
      tick();
      check("rst_no_start", 320'(busy), 320'(0));

      // 2. Round trip: inverse of diffusion(X) is X, held for 10 idle cycles.
      p_vec = m_diff(x_vec);
      run_op(p_vec, y_vec);
      check("roundtrip", y_vec, x_vec);
      for (int i = 0; i < 10; i++) tick();
      check("roundtrip_hold", dout, x_vec);

      // 3. Converse: diffusion(inverse(X)) == X via the reference instance.
      run_op(x_vec, y_vec);
      ref_in = y_vec;
      #1;
      check("converse_ref", ref_out, x_vec);
      check("converse_model", m_diff(y_vec), x_vec);

      // 4. Zero and single-bit inputs.
      run_op(zero_s, y_vec);
      check("zero", y_vec, zero_s);
      bit_s    = '0;
      bit_s[0] = 64'h1;
      run_op(bit_s, y_vec);
      ref_in = y_vec;
      #1;
      check("bit_fwd", ref_out, bit_s);
      check("bit_upper_words", 320'(y_vec[4:1]), 320'(0));
      // Sigma0(1) = bits 0, 36 (rotr 28), 45 (rotr 19); its inverse is word0 = 1.
      sig_s    = '0;
      sig_s[0] = 64'h0000201000000001;
      run_op(sig_s, y_vec);
      check("sigma0_literal", y_vec, bit_s);

      // 5. Starts during RUN and DONE are ignored.
      exp_s = x_vec;
      d0    = n_done;
      start = 1'b1;
      din   = p_vec;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      start = 1'b1;
      din   = alt;
      tick();
      start = 1'b0;
      for (int i = 0; i < 100 && !done; i++) tick();
      check("ign_done_seen", 320'(done), 320'(1));
      start = 1'b1;
      din   = alt;
      tick();
      start = 1'b0;
      check("ign_result", dout, exp_s);
      check("ign_busy_after", 320'(busy), 320'(0));
      for (int i = 0; i < 70; i++) tick();
      check("ign_single_done", 320'(n_done - d0), 320'(1));
      check("ign_hold", dout, exp_s);

      // 6. Reset 30 cycles into RUN, then a fresh run completes.
      start = 1'b1;
      din   = x_vec;
      tick();
      start = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      d0     = n_done;
      resetb = 1'b0;
      tick();
      resetb = 1'b1;
      check("abort_state", dout, zero_s);
      check("abort_busy",  320'(busy), 320'(0));
      check("abort_done",  320'(done), 320'(0));
      for (int i = 0; i < 70; i++) tick();
      check("abort_no_done", 320'(n_done - d0), 320'(0));
      run_op(p_vec, y_vec);
      check("after_abort", y_vec, x_vec);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
